sata_oob_ctrl: RTL and testbench
================================

SATA_OOB_CTRL -- requirements
Module: sata_oob_ctrl

Interface
REQ-001 SHALL have parameter BURST_CYCLES, 160, clk cycles tx_cominit/tx_comwake are held high per OOB burst request.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 880000, clk cycles allowed in any wait state before restarting at COMRESET.
REQ-003 SHALL have parameter ALIGN_NUM, 3, consecutive rx_align_det cycles required to accept device ALIGN.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low; driven by the reset generator output.
REQ-006 SHALL have port rx_cominit_det  input  1  PHY detected COMINIT from device.
REQ-007 SHALL have port rx_comwake_det  input  1  PHY detected COMWAKE from device; level, high while burst present.
REQ-008 SHALL have port rx_align_det  input  1  ALIGN primitive received this cycle.
REQ-009 SHALL have port rx_sync_det  input  1  non-ALIGN primitive (SYNC) received this cycle.
REQ-010 SHALL have port tx_cominit  output  1  request PHY to transmit COMRESET burst.
REQ-011 SHALL have port tx_comwake  output  1  request PHY to transmit COMWAKE burst.
REQ-012 SHALL have port tx_elecidle  output  1  transmitter electrical idle.
REQ-013 SHALL have port tx_align_sel  output  1  1=transmit ALIGN, 0=transmit D10.2 (or SYNC once link up).
REQ-014 SHALL have port link_up  output  1  OOB complete, link established.
REQ-015 SHALL have port retry_cnt  output  8  number of COMRESET restarts since reset, saturating at 255.

Function
REQ-016 SHALL implement Moore FSM states IDLE, COMRESET, WAIT_COMINIT, COMWAKE, WAIT_COMWAKE, WAIT_WAKE_END, SEND_D102, SEND_ALIGN, LINK_UP; outputs decoded from current state only.
REQ-017 IDLE SHALL last exactly one cycle after rst_n deasserts, then enter COMRESET.
REQ-018 COMRESET SHALL drive tx_cominit=1 for exactly BURST_CYCLES cycles, then enter WAIT_COMINIT.
REQ-019 WAIT_COMINIT SHALL enter COMWAKE on rx_cominit_det=1.
REQ-020 COMWAKE SHALL drive tx_comwake=1 for exactly BURST_CYCLES cycles, then enter WAIT_COMWAKE.
REQ-021 WAIT_COMWAKE SHALL enter WAIT_WAKE_END on rx_comwake_det=1; WAIT_WAKE_END SHALL enter SEND_D102 on first cycle rx_comwake_det=0.
REQ-022 tx_elecidle SHALL be 1 in IDLE through WAIT_WAKE_END and 0 in SEND_D102, SEND_ALIGN, LINK_UP.
REQ-023 SEND_D102 SHALL drive tx_align_sel=0, count consecutive rx_align_det cycles, clear the count on any rx_align_det=0 cycle, and enter SEND_ALIGN when the count reaches ALIGN_NUM.
REQ-024 SEND_ALIGN SHALL drive tx_align_sel=1 and enter LINK_UP on rx_sync_det=1.
REQ-025 LINK_UP SHALL drive link_up=1, tx_align_sel=0; rx_cominit_det=1 SHALL return the FSM to COMRESET.
REQ-026 A single 32-bit timer SHALL clear on every state entry; in WAIT_COMINIT, WAIT_COMWAKE, WAIT_WAKE_END, SEND_D102, SEND_ALIGN, reaching TIMEOUT_CYCLES-1 without the exit condition SHALL enter COMRESET next cycle.
REQ-027 Exit condition and timeout in the same cycle: exit condition SHALL win.
REQ-028 Every entry into COMRESET other than the first after reset SHALL increment retry_cnt by one, saturating at 255.
REQ-029 Detector inputs SHALL be ignored in states not listed as consuming them.

Reset
REQ-030 rst_n=0 at a clk edge SHALL force state=IDLE, timer=0, align count=0, retry_cnt=0, tx_cominit=0, tx_comwake=0, tx_elecidle=1, tx_align_sel=0, link_up=0, including mid-burst or from LINK_UP.
REQ-031 No asynchronous reset paths SHALL exist.

Structure
REQ-032 Package sata_oob_pkg SHALL hold the oob_state_e enum typedef and default constants for BURST_CYCLES, TIMEOUT_CYCLES, ALIGN_NUM.
REQ-033 No sub-module SHALL be used; timer, align counter and retry counter are inline.

Verification (BURST_CYCLES=4, TIMEOUT_CYCLES=50, ALIGN_NUM=3)
REQ-034 Nominal: device answers COMINIT, COMWAKE, 3 ALIGNs, SYNC -> tx_cominit high 4 cycles, tx_comwake high 4 cycles, link_up=1, retry_cnt=0.
REQ-035 No COMINIT for 50 cycles in WAIT_COMINIT -> FSM back in COMRESET, retry_cnt=1; repeated 300 times -> retry_cnt=255.
REQ-036 rx_align_det pattern 1,1,0,1,1,1 -> SEND_ALIGN entered only after the final 1.
REQ-037 rx_comwake_det asserted on the exact timeout cycle in WAIT_COMWAKE -> WAIT_WAKE_END entered, no retry.
REQ-038 rst_n=0 for one cycle during COMWAKE and again in LINK_UP -> all outputs at reset values next cycle, sequence restarts from IDLE.
REQ-039 rx_cominit_det=1 in LINK_UP -> link_up=0 and tx_cominit=1 next cycle, retry_cnt increments.

Source files
------------

// File: rtl/sata_oob_pkg.sv
// Shared state encoding and default timing constants for the SATA host OOB controller.
package sata_oob_pkg;

   typedef enum logic [3:0] {
      IDLE,
      COMRESET,
      WAIT_COMINIT,
      COMWAKE,
      WAIT_COMWAKE,
      WAIT_WAKE_END,
      SEND_D102,
      SEND_ALIGN,
      LINK_UP
   } oob_state_e;

   localparam int DEF_BURST_CYCLES   = 160;
   localparam int DEF_TIMEOUT_CYCLES = 880000;
   localparam int DEF_ALIGN_NUM      = 3;

endpackage

// File: rtl/sata_oob_ctrl.sv
// Host-side SATA out-of-band sequencer: COMRESET/COMWAKE handshake, ALIGN lock and
// link-up, with a per-state timeout that restarts the sequence at COMRESET.
module sata_oob_ctrl
   import sata_oob_pkg::*;
#(
   parameter int BURST_CYCLES   = DEF_BURST_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int ALIGN_NUM      = DEF_ALIGN_NUM
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_cominit_det,
   input  logic       rx_comwake_det,
   input  logic       rx_align_det,
   input  logic       rx_sync_det,
   output logic       tx_cominit,
   output logic       tx_comwake,
   output logic       tx_elecidle,
   output logic       tx_align_sel,
   output logic       link_up,
   output logic [7:0] retry_cnt
);

   localparam logic [31:0] BURST_LAST   = 32'(BURST_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  ALIGN_LAST   = 8'(ALIGN_NUM - 1);

   oob_state_e  state;
   oob_state_e  state_next;
   logic [31:0] timer;
   logic [7:0]  align_cnt;
   logic [7:0]  align_cnt_next;
   logic        timed_out;
   logic        burst_done;

   assign timed_out  = (timer == TIMEOUT_LAST);
   assign burst_done = (timer == BURST_LAST);

   // An exit condition is always tested before the timeout so it wins a tie.
   always_comb begin
      state_next     = state;
      align_cnt_next = '0;
      case (state)
         IDLE:          state_next = COMRESET;
         COMRESET:      if (burst_done) state_next = WAIT_COMINIT;
         WAIT_COMINIT: begin
            if (rx_cominit_det)  state_next = COMWAKE;
            else if (timed_out)  state_next = COMRESET;
         end
         COMWAKE:       if (burst_done) state_next = WAIT_COMWAKE;
         WAIT_COMWAKE: begin
            if (rx_comwake_det)  state_next = WAIT_WAKE_END;
            else if (timed_out)  state_next = COMRESET;
         end
         WAIT_WAKE_END: begin
            if (!rx_comwake_det) state_next = SEND_D102;
            else if (timed_out)  state_next = COMRESET;
         end
         SEND_D102: begin
            if (rx_align_det && (align_cnt == ALIGN_LAST)) state_next = SEND_ALIGN;
            else if (timed_out)  state_next = COMRESET;
            else if (rx_align_det) align_cnt_next = align_cnt + 8'd1;
         end
         SEND_ALIGN: begin
            if (rx_sync_det)     state_next = LINK_UP;
            else if (timed_out)  state_next = COMRESET;
         end
         LINK_UP:       if (rx_cominit_det) state_next = COMRESET;
         default:       state_next = IDLE;
      endcase
   end

   always_comb begin
      tx_cominit   = 1'b0;
      tx_comwake   = 1'b0;
      tx_elecidle  = 1'b1;
      tx_align_sel = 1'b0;
      link_up      = 1'b0;
      case (state)
         COMRESET:   tx_cominit = 1'b1;
         COMWAKE:    tx_comwake = 1'b1;
         SEND_D102:  tx_elecidle = 1'b0;
         SEND_ALIGN: begin
            tx_elecidle  = 1'b0;
            tx_align_sel = 1'b1;
         end
         LINK_UP: begin
            tx_elecidle = 1'b0;
            link_up     = 1'b1;
         end
         default: ;
      endcase
   end

   // The only COMRESET entry from IDLE is the first after reset, so it is not a retry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         align_cnt <= '0;
         retry_cnt <= '0;
      end else begin
         state     <= state_next;
         timer     <= (state_next != state) ? '0 : timer + 32'd1;
         align_cnt <= align_cnt_next;
         if ((state_next == COMRESET) && (state != COMRESET) && (state != IDLE)
             && (retry_cnt != 8'hFF))
            retry_cnt <= retry_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_sata_oob_ctrl.sv
// Directed self-checking bench for sata_oob_ctrl with short burst/timeout parameters.
module tb_sata_oob_ctrl;
   import sata_oob_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_cominit_det;
   logic       rx_comwake_det;
   logic       rx_align_det;
   logic       rx_sync_det;
   logic       tx_cominit;
   logic       tx_comwake;
   logic       tx_elecidle;
   logic       tx_align_sel;
   logic       link_up;
   logic [7:0] retry_cnt;

   int total = 0;
   int bad   = 0;

   sata_oob_ctrl #(
      .BURST_CYCLES  (4),
      .TIMEOUT_CYCLES(50),
      .ALIGN_NUM     (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_cominit_det(rx_cominit_det),
      .rx_comwake_det(rx_comwake_det),
      .rx_align_det  (rx_align_det),
      .rx_sync_det   (rx_sync_det),
      .tx_cominit    (tx_cominit),
      .tx_comwake    (tx_comwake),
      .tx_elecidle   (tx_elecidle),
      .tx_align_sel  (tx_align_sel),
      .link_up       (link_up),
      .retry_cnt     (retry_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_outs(input string tag, input logic ci, input logic cw, input logic ei,
                             input logic al, input logic lu, input logic [7:0] rc);
      check({tag, ".tx_cominit"},   32'(tx_cominit),   32'(ci));
      check({tag, ".tx_comwake"},   32'(tx_comwake),   32'(cw));
      check({tag, ".tx_elecidle"},  32'(tx_elecidle),  32'(ei));
      check({tag, ".tx_align_sel"}, 32'(tx_align_sel), 32'(al));
      check({tag, ".link_up"},      32'(link_up),      32'(lu));
      check({tag, ".retry_cnt"},    32'(retry_cnt),    32'(rc));
   endtask

   task automatic check_state(input string tag, input oob_state_e expected);
      check({tag, ".state"}, 32'(dut.state), 32'(expected));
   endtask

   initial begin
      rst_n          = 1'b0;
      rx_cominit_det = 1'b0;
      rx_comwake_det = 1'b0;
      rx_align_det   = 1'b0;
      rx_sync_det    = 1'b0;
      tick(3);
      check_outs("reset", 0, 0, 1, 0, 0, 8'd0);
      check_state("reset", IDLE);

      // Nominal bring-up: 4-cycle COMRESET burst
      rst_n = 1'b1;
      tick();
      check_outs("comreset_c1", 1, 0, 1, 0, 0, 8'd0);
      tick(3);
      check_outs("comreset_c4", 1, 0, 1, 0, 0, 8'd0);
      tick();
      check_outs("wait_cominit", 0, 0, 1, 0, 0, 8'd0);
      check_state("wait_cominit", WAIT_COMINIT);

      rx_cominit_det = 1'b1;
      tick();
      rx_cominit_det = 1'b0;
      check_outs("comwake_c1", 0, 1, 1, 0, 0, 8'd0);
      tick(3);
      check_outs("comwake_c4", 0, 1, 1, 0, 0, 8'd0);
      tick();
      check_outs("wait_comwake", 0, 0, 1, 0, 0, 8'd0);

      rx_comwake_det = 1'b1;
      tick();
      check_state("wake_end_enter", WAIT_WAKE_END);
      tick();
      check_state("wake_end_hold", WAIT_WAKE_END);
      rx_comwake_det = 1'b0;
      tick();
      check_state("send_d102", SEND_D102);
      check_outs("send_d102", 0, 0, 0, 0, 0, 8'd0);

      // ALIGN pattern 1,1,0,1,1,1: the zero restarts the count
      rx_align_det = 1'b1; tick();
      rx_align_det = 1'b1; tick();
      rx_align_det = 1'b0; tick();
      check_state("align_after_110", SEND_D102);
      rx_align_det = 1'b1; tick();
      rx_align_det = 1'b1; tick();
      check_state("align_after_11011", SEND_D102);
      rx_align_det = 1'b1; tick();
      rx_align_det = 1'b0;
      check_state("align_after_110111", SEND_ALIGN);
      check_outs("send_align", 0, 0, 0, 1, 0, 8'd0);

      rx_sync_det = 1'b1;
      tick();
      rx_sync_det = 1'b0;
      check_outs("link_up", 0, 0, 0, 0, 1, 8'd0);

      // Detectors other than COMINIT are ignored in LINK_UP
      rx_align_det   = 1'b1;
      rx_comwake_det = 1'b1;
      tick(2);
      rx_align_det   = 1'b0;
      rx_comwake_det = 1'b0;
      check_state("link_up_hold", LINK_UP);

      // COMINIT from device while linked restarts at COMRESET
      rx_cominit_det = 1'b1;
      tick();
      rx_cominit_det = 1'b0;
      check_outs("link_drop", 1, 0, 1, 0, 0, 8'd1);

      // No COMINIT answer: timeout after 50 cycles in WAIT_COMINIT
      tick(4);
      check_state("to_wait", WAIT_COMINIT);
      tick(49);
      check_outs("to_last_wait", 0, 0, 1, 0, 0, 8'd1);
      tick();
      check_outs("to_restart", 1, 0, 1, 0, 0, 8'd2);

      // Each unanswered round is 4 burst + 50 wait cycles
      for (int i = 0; i < 252; i++) tick(54);
      check("retry_254", 32'(retry_cnt), 32'd254);
      tick(54);
      check("retry_255", 32'(retry_cnt), 32'd255);
      for (int i = 0; i < 47; i++) tick(54);
      check("retry_saturated", 32'(retry_cnt), 32'd255);
      check_state("retry_saturated", COMRESET);

      // Reset for one cycle in the middle of a COMWAKE burst
      tick(4);
      rx_cominit_det = 1'b1;
      tick();
      rx_cominit_det = 1'b0;
      tick();
      check_outs("mid_comwake", 0, 1, 1, 0, 0, 8'd255);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_outs("rst_in_comwake", 0, 0, 1, 0, 0, 8'd0);
      check_state("rst_in_comwake", IDLE);
      tick();
      check_outs("restart_after_rst", 1, 0, 1, 0, 0, 8'd0);

      // COMWAKE seen on the exact timeout cycle: the exit wins
      tick(4);
      rx_cominit_det = 1'b1;
      tick();
      rx_cominit_det = 1'b0;
      tick(4);
      check_state("tie_wait_comwake", WAIT_COMWAKE);
      tick(49);
      check_state("tie_last_cycle", WAIT_COMWAKE);
      rx_comwake_det = 1'b1;
      tick();
      check_state("tie_exit_wins", WAIT_WAKE_END);
      check_outs("tie_no_retry", 0, 0, 1, 0, 0, 8'd0);

      rx_comwake_det = 1'b0;
      tick();
      rx_align_det = 1'b1;
      tick(3);
      rx_align_det = 1'b0;
      rx_sync_det  = 1'b1;
      tick();
      rx_sync_det  = 1'b0;
      check_outs("link_up_2", 0, 0, 0, 0, 1, 8'd0);

      // Reset for one cycle while linked
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_outs("rst_in_link_up", 0, 0, 1, 0, 0, 8'd0);
      check_state("rst_in_link_up", IDLE);
      tick();
      check_outs("restart_after_rst2", 1, 0, 1, 0, 0, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
